// File: rtl/queue_frame_tx_if.sv
// Queue read-port bundle between the frame queue and its serialising consumer.
// master: the consumer that issues dequeue; slave: the queue that answers.
interface queue_frame_tx_if #(
    parameter int WIDTH = 11
);
    logic             q_empty;
    logic [WIDTH-1:0] q_data;
    logic             q_dequeue;

    modport master (
        input  q_empty,
        input  q_data,
        output q_dequeue
    );

    modport slave (
        output q_empty,
        output q_data,
        input  q_dequeue
    );
endinterface

// File: rtl/queue_frame_tx.sv
// queue_frame_tx: pops pre-framed WIDTH-bit words from a queue and shifts them
// out LSB-first on tx, each bit held BAUD_DIV clocks. Every frame passes
// through IDLE -> FETCH -> CAPTURE -> SHIFT, giving a 3-clock idle-high gap.
// Optional macro QUEUE_FRAME_TX_CHECK_EN: drop words whose start bit (bit 0)
// is not 0 or whose stop bit (bit WIDTH-1) is not 1, pulsing frame_err.
module queue_frame_tx #(
    parameter int WIDTH    = 11,
    parameter int BAUD_DIV = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    queue_frame_tx_if.master q_if,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int               BW        = $clog2(WIDTH + 1);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [BW-1:0]    LAST_BIT  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_SHIFT   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_idx;
    logic [15:0]      r_baud;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_dequeue;
    logic [WIDTH-1:0] w_shift_next;

`ifdef QUEUE_FRAME_TX_CHECK_EN
    logic r_err;
    logic w_frame_bad;

    // A word is malformed when its start bit is high or its stop bit is low.
    always_comb begin
        w_frame_bad = q_if.q_data[0] | ~q_if.q_data[WIDTH-1];
    end

    assign frame_err = r_err;
`else
    assign frame_err = 1'b0;
`endif

    // Next shift-register contents once the current bit period ends.
    always_comb begin
        w_shift_next = r_shift >> 1;
    end

    // Frame FSM: fetch one word, capture it, then shift it out bit by bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dequeue <= 1'b0;
`ifdef QUEUE_FRAME_TX_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_dequeue <= 1'b0;
            r_done    <= 1'b0;
`ifdef QUEUE_FRAME_TX_CHECK_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && !q_if.q_empty) begin
                        r_state   <= S_FETCH;
                        r_dequeue <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // The queue presents data the cycle after the pop edge.
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_bit_idx <= '0;
                    r_baud    <= '0;
`ifdef QUEUE_FRAME_TX_CHECK_EN
                    if (w_frame_bad) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else
`endif
                    begin
                        r_shift <= q_if.q_data;
                        r_tx    <= q_if.q_data[0];
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_shift   <= w_shift_next;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tx <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q_if.q_dequeue = r_dequeue;
    assign tx             = r_tx;
    assign busy           = r_busy;
    assign frame_done     = r_done;
endmodule

// File: tb/tb_queue_frame_tx.sv
// Scoreboard bench for queue_frame_tx (WIDTH=11, BAUD_DIV=4).
// Stimulus pushes words into a queue model and their expected values into a
// scoreboard; a negedge monitor reassembles each serial frame and compares.
module tb_queue_frame_tx;
    localparam int W          = 11;
    localparam int BAUD       = 4;
    localparam int FRAME_CLKS = W * BAUD;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic tx;
    logic busy;
    logic frame_done;
    logic frame_err;

    queue_frame_tx_if #(.WIDTH(W)) q_if ();

    queue_frame_tx #(.WIDTH(W), .BAUD_DIV(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .q_if       (q_if.master),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] qm[$];     // queue contents seen by the DUT
    logic [W-1:0] exp_q[$];  // scoreboard of expected frames
    int           gaps[$];   // dequeue cycle minus previous frame_done cycle

    int           ndq = 0;
    int           ndone = 0;
    int           nerr = 0;
    int           last_dq_cyc = 0;
    int           last_done_cyc = -100;
    bit           mon_active = 0;
    int           mon_k = 0;
    logic [W-1:0] mon_word;
    logic [W-1:0] cur_exp;
    bit           cur_bad = 0;
    logic         prev_dq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Queue model: data appears the cycle after a dequeue edge.
    always @(posedge clk) begin
        if (q_if.q_dequeue && qm.size() != 0) q_if.q_data <= qm.pop_front();
        q_if.q_empty <= (qm.size() == 0);
    end

    // Monitor: follows each fetched frame and checks the serial waveform.
    initial begin
        int  idx;
        int  ph;
        bit  done_ok;
        bit  err_ok;
        forever begin
            @(negedge clk);
            done_ok = 0;
            err_ok  = 0;
            if (reset) begin
                mon_active = 0;
                mon_k      = 0;
                prev_dq    = 1'b0;
            end else begin
                if (mon_active) begin
                    mon_k++;
                    if (cur_bad) begin
                        if (mon_k == 1) begin
                            chk("drop_capture_tx", tx, 1);
                        end else begin
                            chk("drop_err_pulse", frame_err, 1);
                            chk("drop_tx_high", tx, 1);
                            chk("drop_busy", busy, 0);
                            $display("frame dropped: word=0x%03h", cur_exp);
                            err_ok = 1;
                            nerr++;
                            mon_active = 0;
                        end
                    end else if (mon_k == 1) begin
                        chk("capture_tx_high", tx, 1);
                        chk("capture_busy", busy, 1);
                    end else if (mon_k < 2 + FRAME_CLKS) begin
                        idx = (mon_k - 2) / BAUD;
                        ph  = (mon_k - 2) % BAUD;
                        if (ph == 0) mon_word[idx] = tx;
                        else chk("bit_hold", tx, mon_word[idx]);
                    end else begin
                        chk("frame_done_pulse", frame_done, 1);
                        chk("end_tx_high", tx, 1);
                        chk("end_busy", busy, 0);
                        chk("frame_word", mon_word, cur_exp);
                        $display("frame %0d: rx=0x%03h exp=0x%03h", ndone, mon_word, cur_exp);
                        done_ok = 1;
                        ndone++;
                        last_done_cyc = cyc;
                        mon_active = 0;
                    end
                end
                if (frame_done && !done_ok) chk("spurious_frame_done", frame_done, 0);
                if (frame_err && !err_ok) chk("spurious_frame_err", frame_err, 0);
                if (q_if.q_dequeue) begin
                    chk("dq_consecutive", prev_dq, 0);
                    chk("dq_outside_fetch", mon_active, 0);
                    chk("dq_unexpected", exp_q.size() == 0, 0);
                    if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                    cur_bad = 0;
`ifdef QUEUE_FRAME_TX_CHECK_EN
                    cur_bad = cur_exp[0] | ~cur_exp[W-1];
`endif
                    gaps.push_back(cyc - last_done_cyc);
                    last_dq_cyc = cyc;
                    ndq++;
                    mon_active = 1;
                    mon_k      = 0;
                    mon_word   = '0;
                end
                prev_dq = q_if.q_dequeue;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] w);
        qm.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && qm.size() == 0 && !mon_active && busy === 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n >= budget, 0);
        repeat (2) tick();
    endtask

    initial begin
        int p;
        int n;
        int c;
        int nd0;
        int ndq0;

        // Reset and idle
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dequeue", q_if.q_dequeue, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        repeat (50) tick();
        chk("idle_no_dequeue", ndq, 0);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        // Single frame 11'b1_0_10100101_0, tx bits 0,1,0,1,0,0,1,0,1,0,1
        p = cyc;
        push(11'h54A);
        wait_idle("single", 200);
        chk("single_dq_latency", last_dq_cyc - p, 2);
        chk("single_done_latency", last_done_cyc - last_dq_cyc, 2 + FRAME_CLKS);
        chk("single_dq_count", ndq, 1);

        // Back-to-back frames
        gaps.delete();
        nd0 = ndone;
        ndq0 = ndq;
        push(11'h6AA);
        push(11'h7FE);
        push(11'h400);
        wait_idle("b2b", 600);
        chk("b2b_dq_count", ndq - ndq0, 3);
        chk("b2b_done_count", ndone - nd0, 3);
        chk("b2b_gap1", (gaps.size() > 1) ? gaps[1] : -1, 1);
        chk("b2b_gap2", (gaps.size() > 2) ? gaps[2] : -1, 1);
        chk("b2b_queue_empty", qm.size(), 0);

        // Enable gating
        push(11'h4F0);
        push(11'h54A);
        n = 0;
        while (!(mon_active && mon_k >= 10) && n < 200) begin tick(); n++; end
        chk("en_start_timeout", n >= 200, 0);
        enable = 1'b0;
        nd0  = ndone;
        ndq0 = ndq;
        n = 0;
        while (ndone == nd0 && n < 200) begin tick(); n++; end
        chk("en_frame1_timeout", n >= 200, 0);
        repeat (20) tick();
        chk("en_no_dequeue", ndq - ndq0, 0);
        chk("en_queue_held", qm.size(), 1);
        enable = 1'b1;
        c = cyc;
        repeat (3) tick();
        chk("en_restart_latency", last_dq_cyc - c, 1);
        wait_idle("en", 200);

        // Reset mid-frame at bit 5
        push(11'h6AA);
        push(11'h4F0);
        n = 0;
        while (!(mon_active && mon_k >= 2 + 5 * BAUD) && n < 200) begin tick(); n++; end
        chk("rstmid_start_timeout", n >= 200, 0);
        nd0 = ndone;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_no_done", frame_done, 0);
        tick();
        reset = 1'b0;
        wait_idle("rstmid", 300);
        chk("rstmid_done_count", ndone - nd0, 1);

`ifdef QUEUE_FRAME_TX_CHECK_EN
        // Malformed word dropped, next one transmitted
        nd0 = ndone;
        push(11'h001);
        push(11'h54A);
        wait_idle("chk", 300);
        chk("chk_err_count", nerr, 1);
        chk("chk_done_count", ndone - nd0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
